// File: rtl/tipi_nib_if.sv
// Pi-side TIPI nibble port: strobe, framing reset and the bidirectional nibble pads.
// Bit 0 is the MSB of each nibble.
interface tipi_nib_if;
    logic       r_clk;
    logic       r_nibrst;
    logic [0:3] r_nib_in;
    logic [0:3] r_nib_out;
    logic       r_nib_oe;

    modport master (
        output r_clk,
        output r_nibrst,
        output r_nib_in,
        input  r_nib_out,
        input  r_nib_oe
    );

    modport slave (
        input  r_clk,
        input  r_nibrst,
        input  r_nib_in,
        output r_nib_out,
        output r_nib_oe
    );
endinterface

// File: rtl/tipi_nib_ctrl.sv
// Pi-side sequencer for the TIPI nibble port: command / data-high / data-low transactions,
// snapshot reads of TD/TC and committed writes to the RD/RC latches.
module tipi_nib_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RD_RESET    = 8'h00,
    parameter logic [7:0] RC_RESET    = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    tipi_nib_if.slave  pi,
    input  logic [0:7] td_q,
    input  logic [0:7] tc_q,
    output logic [0:7] rd_q,
    output logic [0:7] rc_q,
    output logic       rd_wr,
    output logic       rc_wr,
    output logic       busy,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] rst_sync_reg;
    logic                   clk_prev_reg;
    logic [0:2]             cmd_reg;
    logic [0:7]             shadow_reg;
    logic [0:7]             rd_reg, rc_reg;
    logic                   rd_wr_reg, rc_wr_reg, err_reg;
    logic                   commit_reg;
    logic                   nib_edge, nibrst_s;
    logic                   latch_cmd, cap_hi, cap_lo, set_err;
    logic [0:7]             sel_byte;
    logic                   oe;

    assign nibrst_s = rst_sync_reg[SYNC_STAGES-1];
    assign nib_edge = clk_sync_reg[SYNC_STAGES-1] & ~clk_prev_reg;

    always_comb begin
        sel_byte = td_q;
        case (pi.r_nib_in[0:1])
            2'b00:   sel_byte = td_q;
            2'b01:   sel_byte = tc_q;
            2'b10:   sel_byte = rd_reg;
            default: sel_byte = rc_reg;
        endcase
    end

    // Next-state and datapath enables; synced r_nibrst wins over any coincident strobe edge.
    always_comb begin
        state_next = state_reg;
        latch_cmd  = 1'b0;
        cap_hi     = 1'b0;
        cap_lo     = 1'b0;
        set_err    = 1'b0;
        if (nibrst_s) begin
            state_next = IDLE;
        end else if (nib_edge) begin
            case (state_reg)
                IDLE: begin
                    latch_cmd = 1'b1;
                    if (pi.r_nib_in[3]) begin
                        set_err    = 1'b1;
                        state_next = DONE;
                    end else begin
                        set_err    = pi.r_nib_in[2] & ~pi.r_nib_in[0];
                        state_next = HI;
                    end
                end
                HI: begin
                    cap_hi     = cmd_reg[2];
                    state_next = LO;
                end
                LO: begin
                    cap_lo     = cmd_reg[2];
                    state_next = DONE;
                end
                default: state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            clk_sync_reg <= '0;
            rst_sync_reg <= '0;
            clk_prev_reg <= 1'b0;
            cmd_reg      <= '0;
            shadow_reg   <= '0;
            rd_reg       <= RD_RESET;
            rc_reg       <= RC_RESET;
            rd_wr_reg    <= 1'b0;
            rc_wr_reg    <= 1'b0;
            err_reg      <= 1'b0;
            commit_reg   <= 1'b0;
        end else begin
            clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], pi.r_clk};
            rst_sync_reg <= {rst_sync_reg[SYNC_STAGES-2:0], pi.r_nibrst};
            clk_prev_reg <= clk_sync_reg[SYNC_STAGES-1];
            state_reg    <= state_next;
            rd_wr_reg    <= 1'b0;
            rc_wr_reg    <= 1'b0;
            if (nibrst_s) begin
                err_reg    <= 1'b0;
                commit_reg <= 1'b0;
            end else begin
                if (set_err)
                    err_reg <= 1'b1;
                if (latch_cmd) begin
                    cmd_reg <= pi.r_nib_in[0:2];
                    if (!pi.r_nib_in[2])
                        shadow_reg <= sel_byte;
                end
                if (cap_hi)
                    shadow_reg[0:3] <= pi.r_nib_in;
                // Only RD/RC targets commit; a TD/TC write already flagged err and is dropped.
                if (cap_lo) begin
                    shadow_reg[4:7] <= pi.r_nib_in;
                    commit_reg      <= cmd_reg[0];
                end
                if (commit_reg) begin
                    commit_reg <= 1'b0;
                    if (cmd_reg[1]) begin
                        rc_reg    <= shadow_reg;
                        rc_wr_reg <= 1'b1;
                    end else begin
                        rd_reg    <= shadow_reg;
                        rd_wr_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign oe           = ((state_reg == HI) || (state_reg == LO)) && !cmd_reg[2];
    assign pi.r_nib_oe  = oe;
    assign pi.r_nib_out = !oe ? 4'h0 : (state_reg == HI) ? shadow_reg[0:3] : shadow_reg[4:7];
    assign busy         = (state_reg == HI) || (state_reg == LO);
    assign err          = err_reg;
    assign rd_q         = rd_reg;
    assign rc_q         = rc_reg;
    assign rd_wr        = rd_wr_reg;
    assign rc_wr        = rc_wr_reg;
endmodule
